// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex 7-segment scanner with a debounced key that steps an edit cursor.
// Optional: define SEG_BLINK_EN to blink the digit under the cursor.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned BLINK_DIV  = 12500000,
    localparam int unsigned CW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_n,
    input  logic [4*DIGITS-1:0] digit_data,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   seg_en,
    output logic [CW-1:0]       cursor,
    output logic                key_press
);

    localparam int unsigned SDW = $clog2(SCAN_DIV);
    localparam int unsigned DBW = $clog2(DEB_CYCLES);

    if (DIGITS < 2 || DIGITS > 8 || SCAN_DIV < 2 || DEB_CYCLES < 2 || BLINK_DIV < 2)
    begin : g_bad_params
        $error("seg_scan_ctrl: parameter out of range");
    end

    // Scan state
    logic [SDW-1:0]    div_q, div_d;
    logic [CW-1:0]     scan_idx_q, scan_idx_d;
    logic              div_wrap;

    // Display output registers
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] seg_en_q, seg_en_d;
    logic [3:0]        nibble;
    logic [6:0]        seg_dec;
    logic              blank;

    // Key path
    logic              sync1_q, ks_q;
    logic              stable_q, stable_d;
    logic [DBW-1:0]    deb_cnt_q, deb_cnt_d;
    logic              deb_done, press_accept;
    logic [CW-1:0]     cursor_q, cursor_d;
    logic              key_press_q;

    always_comb begin
        div_wrap   = (div_q == SDW'(SCAN_DIV - 1));
        div_d      = div_wrap ? '0 : div_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (div_wrap) begin
            scan_idx_d = (scan_idx_q == CW'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
    end

    always_comb begin
        nibble = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scan_idx_q == CW'(i)) begin
                nibble = digit_data[4*i +: 4];
            end
        end
    end

    always_comb begin
        case (nibble)
            4'h0:    seg_dec = 7'b1111110;
            4'h1:    seg_dec = 7'b0110000;
            4'h2:    seg_dec = 7'b1101101;
            4'h3:    seg_dec = 7'b1111001;
            4'h4:    seg_dec = 7'b0110011;
            4'h5:    seg_dec = 7'b1011011;
            4'h6:    seg_dec = 7'b1011111;
            4'h7:    seg_dec = 7'b1110000;
            4'h8:    seg_dec = 7'b1111111;
            4'h9:    seg_dec = 7'b1111011;
            4'hA:    seg_dec = 7'b1110111;
            4'hB:    seg_dec = 7'b0011111;
            4'hC:    seg_dec = 7'b1001110;
            4'hD:    seg_dec = 7'b0111101;
            4'hE:    seg_dec = 7'b1001111;
            default: seg_dec = 7'b1000111;
        endcase
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BLW = $clog2(BLINK_DIV);

    logic [BLW-1:0] blink_cnt_q;
    logic           blink_on_q;

    // A press restarts the on-phase so the newly selected digit is visible at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (press_accept) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (blink_cnt_q == BLW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_on_q  <= ~blink_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign blank = !blink_on_q && (scan_idx_q == cursor_q);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_d    = blank ? '0 : seg_dec;
        seg_en_d = ~(DIGITS'(1) << scan_idx_q);
    end

    // Any return of ks to the stable level clears the count, so short glitches never land.
    always_comb begin
        deb_done     = (ks_q != stable_q) && (deb_cnt_q == DBW'(DEB_CYCLES - 1));
        press_accept = deb_done && !ks_q;
        stable_d     = deb_done ? ks_q : stable_q;
        if (ks_q == stable_q || deb_done) begin
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
        cursor_d = cursor_q;
        if (press_accept) begin
            cursor_d = (cursor_q == CW'(DIGITS - 1)) ? '0 : cursor_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            scan_idx_q  <= '0;
            seg_q       <= '0;
            seg_en_q    <= '1;
            sync1_q     <= 1'b1;
            ks_q        <= 1'b1;
            stable_q    <= 1'b1;
            deb_cnt_q   <= '0;
            cursor_q    <= '0;
            key_press_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            scan_idx_q  <= scan_idx_d;
            seg_q       <= seg_d;
            seg_en_q    <= seg_en_d;
            sync1_q     <= key_n;
            ks_q        <= sync1_q;
            stable_q    <= stable_d;
            deb_cnt_q   <= deb_cnt_d;
            cursor_q    <= cursor_d;
            key_press_q <= press_accept;
        end
    end

    assign seg       = seg_q;
    assign seg_en    = seg_en_q;
    assign cursor    = cursor_q;
    assign key_press = key_press_q;

endmodule
